// File: rtl/prog_clk_div_pkg.sv
// Shared definitions for the programmable clock divider: run-state encoding,
// minimum legal divisor and output-mode encodings.
package prog_clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } div_state_e;

    localparam int MIN_DIV = 2;

    localparam logic MODE_HALF  = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/clk_div_neg_ext.sv
// Half-cycle extender: re-times the posedge phase onto the falling edge so an
// OR with the original phase stretches the high time by half a CLK_IN cycle.
module clk_div_neg_ext (
    input  logic CLK_IN,
    input  logic REST_N,
    input  logic phase,
    input  logic enable,
    output logic ext
);

    always_ff @(negedge CLK_IN or negedge REST_N) begin
        if (!REST_N) begin
            ext <= 1'b0;
        end else begin
            ext <= phase & enable;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable clock divider: posedge period counter with shadowed divisor/mode,
// glitch-free 50%-duty or single-pulse output, TICK at every period start.
module prog_clk_divider
    import prog_clk_div_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIV_RESET  = 11,
    parameter int MODE_RESET = 0
) (
    input  logic             CLK_IN,
    input  logic             REST_N,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic             MODE_IN,
    output logic             CLK_OUT,
    output logic             TICK,
    output logic             BUSY,
    output logic             ERR,
    output logic [WIDTH-1:0] DIV_ACT
);

    localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DIV_RESET);
    localparam logic [WIDTH-1:0] DIV_MIN  = WIDTH'(MIN_DIV);
    localparam logic             MODE_RST = (MODE_RESET != 0);

    div_state_e       state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] div_act_reg, div_act_next;
    logic             mode_act_reg, mode_act_next;
    logic [WIDTH-1:0] shadow_div_reg;
    logic             shadow_mode_reg;
    logic             err_reg;
    logic             phase_reg, phase_next;
    logic             tick_reg, tick_next;
    logic             running_next;
    logic             boundary;
    logic             ext_en;
    logic             ext;

    // Shadow registers: written by LOAD at any time, consumed only at a boundary or in IDLE.
    always_ff @(posedge CLK_IN or negedge REST_N) begin
        if (!REST_N) begin
            shadow_div_reg  <= DIV_RST;
            shadow_mode_reg <= MODE_RST;
            err_reg         <= 1'b0;
        end else if (LOAD) begin
            shadow_mode_reg <= MODE_IN;
            if (DIV_IN < DIV_MIN) begin
                shadow_div_reg <= DIV_MIN;
                err_reg        <= 1'b1;
            end else begin
                shadow_div_reg <= DIV_IN;
                err_reg        <= 1'b0;
            end
        end
    end

    assign boundary = (cnt_reg == div_act_reg - WIDTH'(1));

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        div_act_next  = div_act_reg;
        mode_act_next = mode_act_reg;

        case (state_reg)
            ST_IDLE: begin
                div_act_next  = shadow_div_reg;
                mode_act_next = shadow_mode_reg;
                cnt_next      = '0;
                if (EN) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_STOP: begin
                if (boundary) begin
                    div_act_next  = shadow_div_reg;
                    mode_act_next = shadow_mode_reg;
                    cnt_next      = '0;
                    // A stop request only takes effect once the period has fully elapsed.
                    state_next    = EN ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_next   = cnt_reg + WIDTH'(1);
                    state_next = EN ? ST_RUN : ST_STOP;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        running_next = (state_next != ST_IDLE);
        tick_next    = running_next && (cnt_next == '0);

        phase_next = 1'b0;
        if (running_next) begin
            if (mode_act_next == MODE_PULSE) begin
                phase_next = (cnt_next == '0);
            end else begin
                phase_next = (cnt_next < (div_act_next >> 1));
            end
        end
    end

    always_ff @(posedge CLK_IN or negedge REST_N) begin
        if (!REST_N) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            div_act_reg  <= DIV_RST;
            mode_act_reg <= MODE_RST;
            phase_reg    <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_act_reg  <= div_act_next;
            mode_act_reg <= mode_act_next;
            phase_reg    <= phase_next;
            tick_reg     <= tick_next;
        end
    end

    // The half-cycle stretch is needed only for odd divisors in 50% mode.
    assign ext_en = (mode_act_reg == MODE_HALF) && div_act_reg[0];

    clk_div_neg_ext u_neg_ext (
        .CLK_IN (CLK_IN),
        .REST_N (REST_N),
        .phase  (phase_reg),
        .enable (ext_en),
        .ext    (ext)
    );

    // phase_reg moves on posedges and ext on negedges, so the OR cannot glitch.
    assign CLK_OUT = phase_reg | ext;
    assign TICK    = tick_reg;
    assign BUSY    = (state_reg != ST_IDLE);
    assign ERR     = err_reg;
    assign DIV_ACT = div_act_reg;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: directed vector table, corner-case
// sequences and randomized traffic checked against a period-level reference model.
module tb_prog_clk_divider;

    localparam int WIDTH = 8;

    logic             CLK_IN  = 1'b0;
    logic             REST_N  = 1'b0;
    logic             EN      = 1'b0;
    logic             LOAD    = 1'b0;
    logic [WIDTH-1:0] DIV_IN  = '0;
    logic             MODE_IN = 1'b0;
    logic             CLK_OUT;
    logic             TICK;
    logic             BUSY;
    logic             ERR;
    logic [WIDTH-1:0] DIV_ACT;

    prog_clk_divider #(
        .WIDTH      (WIDTH),
        .DIV_RESET  (11),
        .MODE_RESET (0)
    ) dut (
        .CLK_IN  (CLK_IN),
        .REST_N  (REST_N),
        .EN      (EN),
        .LOAD    (LOAD),
        .DIV_IN  (DIV_IN),
        .MODE_IN (MODE_IN),
        .CLK_OUT (CLK_OUT),
        .TICK    (TICK),
        .BUSY    (BUSY),
        .ERR     (ERR),
        .DIV_ACT (DIV_ACT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a period is D cycles; high time is D half-cycles (mode 0)
    // or 2 half-cycles (mode 1); a new period starts at a period end iff EN is 1.
    bit m_active;
    int m_pos, m_d, m_mode, m_sd, m_sm;
    bit m_err;

    int s_clk_p, s_clk_n;

    typedef struct {
        int en; int load; int din; int mode;
        int clk_p; int clk_n; int tick; int busy; int err; int div;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_d = 11; m_mode = 0;
        m_sd = 11; m_sm = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int old_sd = m_sd;
        int old_sm = m_sm;
        if (LOAD) begin
            m_sm = int'(MODE_IN);
            if (int'(DIV_IN) < 2) begin m_sd = 2; m_err = 1; end
            else begin m_sd = int'(DIV_IN); m_err = 0; end
        end
        if (!m_active) begin
            m_d = old_sd; m_mode = old_sm; m_pos = 0;
            if (EN) m_active = 1;
        end else if (m_pos == m_d - 1) begin
            m_d = old_sd; m_mode = old_sm; m_pos = 0;
            if (!EN) m_active = 0;
        end else begin
            m_pos++;
        end
    endtask

    function automatic int exp_clk(input int half);
        if (!m_active) return 0;
        return ((2 * m_pos + half) < ((m_mode != 0) ? 2 : m_d)) ? 1 : 0;
    endfunction

    task automatic check_outputs(input string tag, input int half);
        chk({tag, "/clk"},  int'(CLK_OUT), exp_clk(half));
        chk({tag, "/tick"}, int'(TICK),    (m_active && m_pos == 0) ? 1 : 0);
        chk({tag, "/busy"}, int'(BUSY),    m_active ? 1 : 0);
        chk({tag, "/err"},  int'(ERR),     m_err ? 1 : 0);
        chk({tag, "/div"},  int'(DIV_ACT), m_d);
    endtask

    task automatic step(input string tag);
        @(posedge CLK_IN);
        model_edge();
        #1;
        s_clk_p = int'(CLK_OUT);
        check_outputs({tag, "/p"}, 0);
        @(negedge CLK_IN);
        #1;
        s_clk_n = int'(CLK_OUT);
        check_outputs({tag, "/n"}, 1);
    endtask

    task automatic drive(input int en, input int load, input int din, input int mode);
        EN = 1'(en); LOAD = 1'(load); DIV_IN = WIDTH'(din); MODE_IN = 1'(mode);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int hi;
        model_reset();

        // en load din mode | clk_p clk_n tick busy err div
        tbl[0]  = '{0, 1, 4, 0,  0, 0, 0, 0, 0, 11};
        tbl[1]  = '{1, 0, 0, 0,  1, 1, 1, 1, 0, 4};
        tbl[2]  = '{1, 0, 0, 0,  1, 1, 0, 1, 0, 4};
        tbl[3]  = '{1, 0, 0, 0,  0, 0, 0, 1, 0, 4};
        tbl[4]  = '{1, 0, 0, 0,  0, 0, 0, 1, 0, 4};
        tbl[5]  = '{1, 0, 0, 0,  1, 1, 1, 1, 0, 4};
        tbl[6]  = '{1, 1, 0, 0,  1, 1, 0, 1, 1, 4};
        tbl[7]  = '{1, 0, 0, 0,  0, 0, 0, 1, 1, 4};
        tbl[8]  = '{1, 0, 0, 0,  0, 0, 0, 1, 1, 4};
        tbl[9]  = '{1, 0, 0, 0,  1, 1, 1, 1, 1, 2};
        tbl[10] = '{1, 0, 0, 0,  0, 0, 0, 1, 1, 2};
        tbl[11] = '{1, 0, 0, 0,  1, 1, 1, 1, 1, 2};
        tbl[12] = '{1, 1, 9, 0,  0, 0, 0, 1, 0, 2};
        tbl[13] = '{1, 0, 0, 0,  1, 1, 1, 1, 0, 9};
        tbl[14] = '{0, 0, 0, 0,  1, 1, 0, 1, 0, 9};

        // Reset state, checked before any clock edge is seen with REST_N high.
        #12;
        chk("reset/clk",  int'(CLK_OUT), 0);
        chk("reset/tick", int'(TICK),    0);
        chk("reset/busy", int'(BUSY),    0);
        chk("reset/err",  int'(ERR),     0);
        chk("reset/div",  int'(DIV_ACT), 11);
        REST_N = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].en, tbl[i].load, tbl[i].din, tbl[i].mode);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d/clk_p", i), s_clk_p,         tbl[i].clk_p);
            chk($sformatf("vec%0d/clk_n", i), s_clk_n,         tbl[i].clk_n);
            chk($sformatf("vec%0d/tick", i),  int'(TICK),      tbl[i].tick);
            chk($sformatf("vec%0d/busy", i),  int'(BUSY),      tbl[i].busy);
            chk($sformatf("vec%0d/err", i),   int'(ERR),       tbl[i].err);
            chk($sformatf("vec%0d/div", i),   int'(DIV_ACT),   tbl[i].div);
            $display("vec %0d: en=%0d load=%0d din=%0d -> clk=%0d%0d tick=%0d busy=%0d err=%0d div=%0d",
                     i, tbl[i].en, tbl[i].load, tbl[i].din, s_clk_p, s_clk_n,
                     int'(TICK), int'(BUSY), int'(ERR), int'(DIV_ACT));
        end
        drive(0, 0, 0, 0);
        n = 0;
        while (m_active && n < 300) begin step("drain"); n++; end
        chk("drain/busy", int'(BUSY), 0);

        // Odd divisor 5: two periods carry 10 high half-cycles.
        drive(0, 1, 5, 0); step("d5_load");
        drive(1, 0, 0, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin step("d5_run"); hi += s_clk_p + s_clk_n; end
        chk("d5/high_halves", hi, 10);
        $display("seq d5: high half-cycles over two periods = %0d", hi);

        // Divisor 4 running, LOAD 7 mid-period, then LOAD on a boundary edge.
        drive(1, 1, 4, 0); step("d4_load"); drive(1, 0, 0, 0);
        n = 0;
        while (!(m_d == 4 && m_pos == 0) && n < 40) begin step("d4_wait"); n++; end
        chk("d4/reached", (n < 40) ? 1 : 0, 1);
        step("d4_cnt1");
        drive(1, 1, 7, 0); step("d7_load"); drive(1, 0, 0, 0);
        chk("d7/cur_div", int'(DIV_ACT), 4);
        n = 0;
        while (m_pos != 0 && n < 20) begin step("d7_wait"); n++; end
        chk("d7/steps_to_boundary", n, 2);
        chk("d7/new_div", int'(DIV_ACT), 7);
        hi = s_clk_p + s_clk_n;
        for (int i = 0; i < 6; i++) begin step("d7_run"); hi += s_clk_p + s_clk_n; end
        chk("d7/high_halves", hi, 7);
        drive(1, 1, 3, 0); step("d3_bnd_load"); drive(1, 0, 0, 0);
        chk("d3/bnd_div_kept", int'(DIV_ACT), 7);
        for (int i = 0; i < 7; i++) step("d3_wait");
        chk("d3/applied", int'(DIV_ACT), 3);
        $display("seq d4->d7->d3: div=%0d", int'(DIV_ACT));

        // Divisor 6, EN dropped at CNT=2: period completes, then a restart ticks at once.
        drive(1, 1, 6, 0); step("d6_load"); drive(1, 0, 0, 0);
        n = 0;
        while (!(m_d == 6 && m_pos == 2) && n < 40) begin step("d6_wait"); n++; end
        chk("d6/reached", (n < 40) ? 1 : 0, 1);
        drive(0, 0, 0, 0);
        n = 0;
        while (m_active && n < 20) begin step("d6_stop"); n++; end
        chk("d6/stop_steps", n, 4);
        chk("d6/idle_clk",  int'(CLK_OUT), 0);
        chk("d6/idle_busy", int'(BUSY),    0);
        drive(1, 0, 0, 0); step("d6_restart");
        chk("d6/restart_tick", int'(TICK),    1);
        chk("d6/restart_clk",  s_clk_p,       1);
        $display("seq d6 stop/restart: stop took %0d cycles", n);

        // Mode 1, divisor 3, asynchronous reset during the CNT=0 pulse.
        drive(1, 1, 3, 1); step("m1_load"); drive(1, 0, 0, 0);
        n = 0;
        while (!(m_d == 3 && m_mode == 1 && m_pos == 0) && n < 40) begin step("m1_wait"); n++; end
        chk("m1/pulse_high", int'(CLK_OUT), 1);
        #1 REST_N = 1'b0;
        #1;
        model_reset();
        chk("m1rst/clk",  int'(CLK_OUT), 0);
        chk("m1rst/tick", int'(TICK),    0);
        chk("m1rst/busy", int'(BUSY),    0);
        chk("m1rst/div",  int'(DIV_ACT), 11);
        drive(0, 0, 0, 0);
        #1 REST_N = 1'b1;
        for (int i = 0; i < 3; i++) step("m1_post");
        chk("m1post/div", int'(DIV_ACT), 11);
        $display("seq mode1 reset: div after release=%0d", int'(DIV_ACT));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            int din;
            if ($urandom_range(0, 39) == 0) EN = ~EN;
            LOAD = ($urandom_range(0, 15) == 0);
            din = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
            DIV_IN = WIDTH'(din);
            MODE_IN = 1'($urandom_range(0, 1));
            if (LOAD) $display("rand %0d: LOAD din=%0d mode=%0d en=%0d", i, din, int'(MODE_IN), int'(EN));
            step("rand");
            if ($urandom_range(0, 299) == 0) begin
                #1 REST_N = 1'b0;
                #1;
                model_reset();
                chk("rand_rst/clk",  int'(CLK_OUT), 0);
                chk("rand_rst/busy", int'(BUSY),    0);
                #1 REST_N = 1'b1;
                $display("rand %0d: reset pulse", i);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8: divisor width; legal divisor range is 2..2^WIDTH-1.
REQ-002 SHALL have parameter DIV_RESET, default 11: active divisor after reset; must be >= 2.
REQ-003 SHALL have parameter MODE_RESET, default 0: active mode after reset (0 = 50% duty, 1 = single-cycle pulse).
REQ-004 SHALL have port CLK_IN, input, 1 bit: the single clock; all flops are clocked by it (posedge, plus one negedge flop).
REQ-005 SHALL have port REST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port EN, input, 1 bit: run request; output toggles only while running.
REQ-007 SHALL have port LOAD, input, 1 bit: single-cycle strobe capturing DIV_IN/MODE_IN into the shadow registers.
REQ-008 SHALL have port DIV_IN, input, WIDTH bits: requested divisor.
REQ-009 SHALL have port MODE_IN, input, 1 bit: requested mode.
REQ-010 SHALL have port CLK_OUT, output, 1 bit: divided clock, glitch-free.
REQ-011 SHALL have port TICK, output, 1 bit: high for one CLK_IN cycle starting at each CLK_OUT period start.
REQ-012 SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port ERR, output, 1 bit: sticky flag indicating that an illegal divisor was loaded.
REQ-014 SHALL have port DIV_ACT, output, WIDTH bits: the divisor in use for the current period.

Function
REQ-015 SHALL implement states IDLE, RUN and STOP: IDLE->RUN when EN=1 is sampled; RUN->STOP when EN=0 is sampled; STOP->IDLE at the end of the current period; STOP->RUN if EN=1 is sampled before the period ends.
REQ-016 SHALL use a posedge counter CNT that runs 0..D-1 in RUN/STOP and wraps to 0, where D = DIV_ACT; the cycle in which CNT=0 is the period start.
REQ-017 SHALL raise CLK_OUT and TICK on the first posedge after EN=1 is sampled in IDLE (latency 1 cycle).
REQ-018 Mode 0, even D: CLK_OUT SHALL be high for exactly D/2 cycles (CNT < D/2) and low for D/2 cycles.
REQ-019 Mode 0, odd D: a posedge phase register SHALL be high while CNT < (D-1)/2; a negedge register SHALL copy it half a cycle later; CLK_OUT SHALL be the OR of the two, giving a high time of D/2 cycles (e.g. 2.5 of 5).
REQ-020 Mode 1: CLK_OUT SHALL be high only while CNT=0 (one CLK_IN cycle per period); the negedge register SHALL be forced low.
REQ-021 CLK_OUT SHALL be driven only from registers, or from an OR of two registers whose edges never coincide; no combinational path from DIV_IN, EN or LOAD to CLK_OUT is allowed.
REQ-022 LOAD=1 SHALL write the shadow registers; on a legal DIV_IN (>= 2) it SHALL also clear ERR.
REQ-023 On DIV_IN < 2, LOAD SHALL write 2 into the shadow divisor and set ERR.
REQ-024 Active divisor and mode SHALL update from the shadow only at a period boundary (posedge where CNT wraps D-1->0), or on any posedge while IDLE; this rule guarantees no truncated or stretched periods.
REQ-025 LOAD coinciding with a boundary edge SHALL take effect at the next boundary; the current period uses the previous shadow.
REQ-026 A second LOAD before the boundary SHALL overwrite the first; only the last value applies.
REQ-027 EN=0 mid-period SHALL let the current period complete fully; CNT then holds at 0, CLK_OUT=0 and TICK=0 in IDLE.
REQ-028 Simultaneous EN=0 and LOAD SHALL honour both: the shadow is written and applied in IDLE.
REQ-029 DIV_ACT SHALL equal the D in force for the period in progress.

Reset
REQ-030 REST_N=0 SHALL asynchronously force: state=IDLE, CNT=0, both phase registers low, CLK_OUT=0, TICK=0, BUSY=0, ERR=0, shadow and DIV_ACT=DIV_RESET, mode=MODE_RESET.
REQ-031 Reset mid-period SHALL drop CLK_OUT immediately; reset deassertion SHALL behave as a fresh IDLE with no partial period.

Structure
REQ-032 Package prog_clk_div_pkg SHALL hold the state enumeration, MIN_DIV=2 and the mode encodings.
REQ-033 The negedge half-cycle extender SHALL be one sub-module, clk_div_neg_ext (inputs CLK_IN, REST_N, phase, enable; output ext).

Verification
REQ-034 Reset, DIV_IN=4, LOAD, EN=1 -> CLK_OUT is 2 high / 2 low cycles; TICK fires every 4 cycles; DIV_ACT=4.
REQ-035 Reset, DIV_IN=5, mode 0, run -> high time 2.5 cycles, period 5 cycles; no glitch at the OR.
REQ-036 Running D=4, LOAD 7 at CNT=1 -> the current period stays 4; the next period is 7 with high time 3.5; LOAD on a boundary edge applies one period later.
REQ-037 Running D=6, EN=0 at CNT=2 -> 6 cycles complete, then CLK_OUT=0 and BUSY=0; EN=1 -> TICK on the next edge.
REQ-038 LOAD DIV_IN=0 -> ERR=1, D=2, CLK_OUT 1/1; a later LOAD of 9 -> ERR=0.
REQ-039 Mode 1, D=3, REST_N pulsed low at CNT=0 -> CLK_OUT falls asynchronously; after release everything holds reset values and DIV_ACT=11.
